sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock, first-word-fall-through FIFO with valid/ready handshakes on both the write and read sides.
- Used as the 128-bit block/command buffer between the AES controller input assembler and the AES core.
- The write side is driven by a registered producer. The read side is consumed by the core's stream interface.

Parameters:
- ADDR_WIDTH, 4: log2 of the FIFO depth. Depth = 2^ADDR_WIDTH entries (16 by default).
- DATA_WIDTH, 128: entry width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- fifo_write_tvalid  input  1  producer has valid data on fifo_wdata.
- fifo_write_tready  output  1  FIFO can accept a word (not full).
- fifo_wdata  input  DATA_WIDTH  write data.
- fifo_read_tready  input  1  consumer accepts the word on fifo_rdata.
- fifo_read_tvalid  output  1  FIFO holds at least one word (not empty).
- fifo_rdata  output  DATA_WIDTH  head-of-queue word; valid while fifo_read_tvalid=1.

Behaviour:
- Storage:
  - Memory array of 2^ADDR_WIDTH x DATA_WIDTH.
  - Write and read pointers are ADDR_WIDTH+1 bits wide. The extra MSB disambiguates full from empty.
- Full/empty flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low ADDR_WIDTH bits equal and MSBs differ.
- Handshake outputs:
  - fifo_write_tready = !full. It depends on state only, never on fifo_write_tvalid.
  - fifo_read_tvalid = !empty. It depends on state only, never on fifo_read_tready.
- Transfers:
  - Write handshake = fifo_write_tvalid && fifo_write_tready. On it: mem[wr_ptr[ADDR_WIDTH-1:0]] <= fifo_wdata; wr_ptr increments.
  - Read handshake = fifo_read_tvalid && fifo_read_tready. On it: rd_ptr increments.
  - Both pointers wrap naturally modulo 2^(ADDR_WIDTH+1).
- Output data: fifo_rdata = mem[rd_ptr[ADDR_WIDTH-1:0]], combinational (FWFT). Holds stable while tvalid=1 and no read handshake occurs.
- Latency:
  - A word written in cycle N appears on fifo_rdata, with fifo_read_tvalid=1, in cycle N+1 when the FIFO was empty.
  - After a read handshake, the next entry is presented in the following cycle.
- Simultaneous write and read in one cycle:
  - Both take effect and occupancy is unchanged.
  - When full, the write is refused (tready=0), so only the read occurs.
  - When empty, the read is impossible (tvalid=0), so only the write occurs.
- Write attempted while full: data is ignored; pointers and memory are unchanged.
- Read attempted while empty: ignored; rd_ptr is unchanged.
- Reset (reset=0, asynchronous assert, synchronous deassert to clk):
  - wr_ptr = rd_ptr = 0.
  - fifo_read_tvalid = 0 and fifo_write_tready = 1 immediately.
  - Memory contents need not be cleared. fifo_rdata is don't-care while tvalid=0.
  - Reset mid-operation discards all stored words.
- Throughput: one write and one read per cycle sustained.

Optional Feature:
- Macro: FIFO_COUNT_EN.
- Defined:
  - Adds output port fifo_count [ADDR_WIDTH:0] = wr_ptr - rd_ptr.
  - Range 0..2^ADDR_WIDTH. Updated the same cycle as the pointers; reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> fifo_read_tvalid=0, fifo_write_tready=1. With FIFO_COUNT_EN: fifo_count=0.
- Write 0x...01 with read_tready=0 -> next cycle fifo_read_tvalid=1, fifo_rdata=0x...01. Assert read_tready one cycle -> tvalid=0 the following cycle.
- Write 16 words 0..15 with no reads (defaults) -> tready=0 after the 16th. A 17th write of 0xDEAD is ignored. Reading 16 words returns 0..15 in order, then tvalid=0.
- Fill to 15 entries, then write and read in the same cycle for 40 cycles -> occupancy stays 15, output order preserved across pointer wrap, tready stays 1.
- When full, assert write_tvalid and read_tready together -> only the read occurs. Next cycle tready=1, count=15.
- Assert reset=0 asynchronously mid-stream with 7 entries -> tvalid drops to 0 without waiting for a clock edge. After release, the first new write is read back correctly.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on the write and read sides. It buffers 128-bit AES blocks and
// commands between the input assembler and the AES core.
//
// Optional feature: define FIFO_COUNT_EN to add the fifo_count occupancy
// output. When the macro is undefined, the port and its logic are absent.
//
// Pointers are ADDR_WIDTH+1 bits wide. The extra MSB tells full apart from
// empty when the low address bits are equal.
module sync_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_write_tvalid,
  output logic                  fifo_write_tready,
  input  logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_read_tready,
  output logic                  fifo_read_tvalid,
  output logic [DATA_WIDTH-1:0] fifo_rdata
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   fifo_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  // Storage is read combinationally so the head word falls through with no
  // extra cycle. For this reason it maps to distributed RAM, not block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  full, empty;
  logic                  write_fire, read_fire;

  assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];

  // The status flags depend only on the pointer state. They never depend on
  // the partner's valid or ready, so no combinational path crosses the FIFO.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_addr == rd_addr) &&
                 (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);

  assign fifo_write_tready = !full;
  assign fifo_read_tvalid  = !empty;

  // A refused write (full) or refused read (empty) simply does not fire.
  assign write_fire = fifo_write_tvalid && !full;
  assign read_fire  = fifo_read_tready && !empty;

  assign fifo_rdata = mem[rd_addr];

`ifdef FIFO_COUNT_EN
  // Modular subtraction of the extended pointers gives 0..DEPTH directly.
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
`endif

  // Pointer advance. Each pointer wraps naturally at 2^(ADDR_WIDTH+1).
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (write_fire) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (read_fire) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
  end

  // Pointer registers. Reset empties the FIFO at once and discards its contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Memory write. No reset is needed, because stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      mem[wr_addr] <= fifo_wdata;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo with default parameters.
// A scoreboard queue receives every accepted write. The head of the queue
// must match fifo_rdata in every cycle where the model holds data. The queue
// is popped on each modelled read handshake.
module tb_sync_fifo;

  localparam int AW    = 4;
  localparam int DW    = 128;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          fifo_write_tvalid;
  logic          fifo_write_tready;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_read_tready;
  logic          fifo_read_tvalid;
  logic [DW-1:0] fifo_rdata;
`ifdef FIFO_COUNT_EN
  logic [AW:0]   fifo_count;
`endif

  sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_write_tvalid (fifo_write_tvalid),
    .fifo_write_tready (fifo_write_tready),
    .fifo_wdata        (fifo_wdata),
    .fifo_read_tready  (fifo_read_tready),
    .fifo_read_tvalid  (fifo_read_tvalid),
    .fifo_rdata        (fifo_rdata)
`ifdef FIFO_COUNT_EN
    ,
    .fifo_count        (fifo_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] sb_q[$];
  int            model_cnt = 0;

  task automatic check_value(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The task drives the inputs and checks the outputs on the
  // falling edge against the model. It then updates the model at the rising edge.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic do_w, do_r;
    fifo_write_tvalid = wv;
    fifo_wdata        = wd;
    fifo_read_tready  = rr;
    @(negedge clk);
    check_value("wready", DW'(fifo_write_tready), DW'(model_cnt < DEPTH));
    check_value("rvalid", DW'(fifo_read_tvalid), DW'(model_cnt != 0));
    if (model_cnt != 0) check_value("rdata", fifo_rdata, sb_q[0]);
`ifdef FIFO_COUNT_EN
    check_value("count", DW'(fifo_count), DW'(model_cnt));
`endif
    do_w = wv && (model_cnt < DEPTH);
    do_r = rr && (model_cnt != 0);
    @(posedge clk);
    if (do_r) begin
      void'(sb_q.pop_front());
      model_cnt--;
    end
    if (do_w) begin
      sb_q.push_back(wd);
      model_cnt++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b0;
    fifo_write_tvalid = 1'b0;
    fifo_wdata        = '0;
    fifo_read_tready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset followed by idle cycles
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // A single word falls through, then one read empties the FIFO again
    step(1'b1, DW'(1), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Fill to capacity, attempt a refused write, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, DW'(32'hDEAD), 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Full, with write and read asserted together: only the read may occur
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i + 200), 1'b0);
    step(1'b1, DW'(32'hBEEF), 1'b1);
    step(1'b0, '0, 1'b0);

    // Sustained simultaneous traffic at 15 entries, across pointer wrap
    for (int i = 0; i < 40; i++) step(1'b1, DW'(i + 1000), 1'b1);
    step(1'b0, '0, 1'b0);

    // Drain to 7 entries, then apply an asynchronous reset mid-cycle
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    fifo_write_tvalid = 1'b1;
    fifo_wdata        = DW'(32'h5555);
    #2;
    reset = 1'b0;
    #1;
    check_value("async_rvalid", DW'(fifo_read_tvalid), DW'(0));
    check_value("async_wready", DW'(fifo_write_tready), DW'(1));
`ifdef FIFO_COUNT_EN
    check_value("async_count", DW'(fifo_count), DW'(0));
`endif
    fifo_write_tvalid = 1'b0;
    fifo_wdata        = '0;
    sb_q.delete();
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0);
    step(1'b1, {4{32'hCAFE_F00D}}, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
